// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver clocked directly from the system clock.
// A baud-tick generator drives a per-bit sample counter.
// Each bit is decided by a 3-sample majority vote around mid-bit.
// A received word is held with a valid/ack handshake, per-word error flags and a sticky overrun flag.
`timescale 1ns/1ps

module uart_rx_os #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_50,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic ODD_PARITY = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync1;
    logic                 sync2;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [SW-1:0]        s_cnt;
    logic                 samp_a;
    logic                 samp_b;
    logic                 maj;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 ferr_acc;
    logic                 perr_acc;
    logic                 hi_run;
    logic                 start_det;
    logic                 at_vote;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 complete;
    logic                 frame_bad;

    // Bit decision: two of the three mid-bit samples win.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign rx_s      = sync2;
    assign tick      = (tick_cnt == TW'(DIV - 1));
    assign start_det = (state == IDLE) && !rx_s;
    assign at_vote   = tick && (s_cnt == SW'(M + 1));
    assign bit_end   = tick && (s_cnt == SW'(OVERSAMPLE - 1));
    assign maj       = majority3(samp_a, samp_b, rx_s);
    assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
    assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    // The frame ends at the vote of the last stop bit, leaving half a bit to resync.
    assign complete  = (state == STOP) && at_vote && last_stop;
    assign frame_bad = ferr_acc | ~maj;
    assign rx_busy   = (state != IDLE);

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
        end
    end

    // Baud tick generator, re-phased to the detected start edge.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (start_det || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (at_vote && maj) state_next = IDLE;
                else if (bit_end)   state_next = DATA;
            end
            DATA: begin
                if (bit_end && last_data) state_next = (PARITY != 0) ? PAR : STOP;
            end
            PAR: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (complete) state_next = frame_bad ? WAIT_IDLE : IDLE;
            end
            WAIT_IDLE: begin
                if (tick && hi_run && rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-bit timing, sampling, shifting and error accumulation for the frame in flight.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            s_cnt    <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
            hi_run   <= 1'b0;
        end else if (start_det) begin
            s_cnt    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
            hi_run   <= 1'b0;
        end else begin
            if (tick && state != IDLE && state != WAIT_IDLE) begin
                s_cnt <= bit_end ? '0 : s_cnt + SW'(1);
                if (s_cnt == SW'(M - 1)) samp_a <= rx_s;
                if (s_cnt == SW'(M))     samp_b <= rx_s;
            end
            if (state == DATA && at_vote) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (state == DATA && bit_end && !last_data) bit_cnt <= bit_cnt + BW'(1);
            if (state == PAR && at_vote) perr_acc <= (^shreg) ^ maj ^ ODD_PARITY;
            if (state == STOP && at_vote && !maj) ferr_acc <= 1'b1;
            if (state == STOP && bit_end) stop_cnt <= 1'b1;
            // A full tick interval of high line is needed before leaving WAIT_IDLE.
            if (state == WAIT_IDLE) begin
                if (!rx_s)     hi_run <= 1'b0;
                else if (tick) hi_run <= 1'b1;
            end else begin
                hi_run <= 1'b0;
            end
        end
    end

    // Holding register and handshake; a new word always wins over a same-cycle ack.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (complete) begin
            rx_data    <= shreg;
            frame_err  <= frame_bad;
            parity_err <= perr_acc;
            rx_valid   <= 1'b1;
            if (rx_valid && !rx_ack) rx_overrun <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: randomized and directed frames into an 8N1 and an 8E1 receiver.
// Expected words are queued at send time and consumed by per-instance monitors.
`timescale 1ns/1ps

module tb_uart_rx_os;

    localparam int PER = 160;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ack_a, ack_b;
    logic       ack_mon_a = 1'b0;
    logic       ack_stim_a = 1'b0;
    logic       ack_mon_b = 1'b0;
    logic       fe_a, fe_b, pe_a, pe_b, ovr_a, ovr_b, busy_a, busy_b;
    logic       mon_en_a = 1'b1;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    exp_t       qa[$];
    exp_t       qb[$];

    assign ack_a = ack_mon_a | ack_stim_a;
    assign ack_b = ack_mon_b;

    uart_rx_os #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk_50(clk), .rst(rst), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ack(ack_a), .frame_err(fe_a), .parity_err(pe_a), .rx_overrun(ovr_a),
        .rx_busy(busy_a)
    );

    uart_rx_os #(.CLK_FREQ(1600000), .BAUD(10000), .OVERSAMPLE(16),
                 .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk_50(clk), .rst(rst), .rx_in(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ack(ack_b), .frame_err(fe_b), .parity_err(pe_b), .rx_overrun(ovr_b),
        .rx_busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
        end
    endtask

    // Reference: a word carries its data; stop low -> frame error; even parity mismatch -> parity error.
    function automatic exp_t model(input logic [7:0] d, input bit use_par, input logic pbit,
                                   input logic stop_v);
        exp_t e;
        e.d  = d;
        e.fe = ~stop_v;
        e.pe = use_par ? ((($countones(d) + int'(pbit)) % 2) != 0) : 1'b0;
        return e;
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v, input int n);
        if (which == 0) rx_a = v;
        else            rx_b = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int which, input logic [7:0] d, input bit use_par, input logic pbit,
                        input logic stop_v, input int per);
        drive(which, 1'b0, per);
        for (int i = 0; i < 8; i++) drive(which, d[i], per);
        if (use_par) drive(which, pbit, per);
        drive(which, stop_v, per);
        drive(which, 1'b1, per);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, " data_a"}, 32'(data_a), 32'd0);
        chk({tag, " valid_a"}, 32'(valid_a), 32'd0);
        chk({tag, " fe_a"}, 32'(fe_a), 32'd0);
        chk({tag, " pe_a"}, 32'(pe_a), 32'd0);
        chk({tag, " ovr_a"}, 32'(ovr_a), 32'd0);
        chk({tag, " busy_a"}, 32'(busy_a), 32'd0);
    endtask

    // Monitor for the 8N1 receiver: compare every presented word, then consume it.
    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en_a && valid_a) begin
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_a unexpected word: got %02h want none", data_a);
                end else begin
                    e = qa.pop_front();
                    chk("mon_a data", 32'(data_a), 32'(e.d));
                    chk("mon_a frame_err", 32'(fe_a), 32'(e.fe));
                    chk("mon_a parity_err", 32'(pe_a), 32'(e.pe));
                end
                ack_mon_a = 1'b1;
                @(negedge clk);
                ack_mon_a = 1'b0;
            end
        end
    end

    // Monitor for the 8E1 receiver.
    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_b) begin
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mon_b unexpected word: got %02h want none", data_b);
                end else begin
                    e = qb.pop_front();
                    chk("mon_b data", 32'(data_b), 32'(e.d));
                    chk("mon_b frame_err", 32'(fe_b), 32'(e.fe));
                    chk("mon_b parity_err", 32'(pe_b), 32'(e.pe));
                end
                ack_mon_b = 1'b1;
                @(negedge clk);
                ack_mon_b = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int k;
        int c0;
        int c1;
        int lat;
        logic [7:0] d;
        logic pb;
        logic sv;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        chk_zero_a("reset");
        chk("reset data_b", 32'(data_b), 32'd0);
        chk("reset busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        drive(0, 1'b1, 50);

        // Two clean 8N1 words
        qa.push_back(model(8'h55, 0, 1'b0, 1'b1));
        send(0, 8'h55, 0, 1'b0, 1'b1, PER);
        qa.push_back(model(8'hA3, 0, 1'b0, 1'b1));
        send(0, 8'hA3, 0, 1'b0, 1'b1, PER);
        drive(0, 1'b1, 100);

        // Glitch shorter than half a bit must not start a frame
        drive(0, 1'b0, 10);
        chk("glitch busy", 32'(busy_a), 32'd1);
        drive(0, 1'b0, 30);
        rx_a = 1'b1;
        n = 0;
        while (busy_a && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("glitch busy drop within bit", 32'(n <= PER), 32'd1);
        align();
        drive(0, 1'b1, 200);

        // Even parity: correct and wrong parity bit on the same word
        qb.push_back(model(8'hA3, 1, 1'b0, 1'b1));
        send(1, 8'hA3, 1, 1'b0, 1'b1, PER);
        qb.push_back(model(8'hA3, 1, 1'b1, 1'b1));
        send(1, 8'hA3, 1, 1'b1, 1'b1, PER);

        // Break: line held low through the stop bit for three bit times
        qa.push_back(model(8'h5A, 0, 1'b0, 1'b0));
        drive(0, 1'b0, PER);
        for (int i = 0; i < 8; i++) drive(0, k[0] ^ k[0] ^ 8'h5A >> i, PER);
        drive(0, 1'b0, 3 * PER);
        chk("break no new word", 32'(valid_a), 32'd0);
        chk("break busy", 32'(busy_a), 32'd1);
        drive(0, 1'b1, 2 * PER);
        qa.push_back(model(8'h3C, 0, 1'b0, 1'b1));
        send(0, 8'h3C, 0, 1'b0, 1'b1, PER);
        drive(0, 1'b1, 100);

        // Overrun: two words without ack
        mon_en_a = 1'b0;
        c0 = cyc;
        c1 = cyc;
        fork
            send(0, 8'h11, 0, 1'b0, 1'b1, PER);
            begin
                n = 0;
                while (!valid_a && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                c1 = cyc;
            end
        join
        lat = c1 - c0;
        chk("latency start->valid", 32'(lat >= 1530 && lat <= 1560), 32'd1);
        chk("ovr first valid", 32'(valid_a), 32'd1);
        chk("ovr first data", 32'(data_a), 32'h11);
        drive(0, 1'b1, 100);
        send(0, 8'h22, 0, 1'b0, 1'b1, PER);
        chk("ovr data", 32'(data_a), 32'h22);
        chk("ovr flag", 32'(ovr_a), 32'd1);
        chk("ovr valid", 32'(valid_a), 32'd1);
        rst = 1'b1;
        align();
        rst = 1'b0;
        chk("ovr cleared by rst", 32'(ovr_a), 32'd0);
        drive(0, 1'b1, 50);

        // Ack on the completion cycle of the second word: no overrun
        send(0, 8'h11, 0, 1'b0, 1'b1, PER);
        drive(0, 1'b1, 100);
        chk("sim-ack first valid", 32'(valid_a), 32'd1);
        c0 = cyc;
        fork
            send(0, 8'h22, 0, 1'b0, 1'b1, PER);
            begin
                k = 0;
                do begin
                    @(posedge clk);
                    #1;
                    k++;
                end while (cyc != c0 + lat - 1 && k < 5000);
                ack_stim_a = 1'b1;
                @(posedge clk);
                #1;
                ack_stim_a = 1'b0;
                chk("sim-ack valid", 32'(valid_a), 32'd1);
                chk("sim-ack overrun", 32'(ovr_a), 32'd0);
                chk("sim-ack data", 32'(data_a), 32'h22);
            end
        join
        ack_stim_a = 1'b1;
        align();
        ack_stim_a = 1'b0;
        chk("ack clears valid", 32'(valid_a), 32'd0);
        chk("ack holds data", 32'(data_a), 32'h22);
        mon_en_a = 1'b1;
        drive(0, 1'b1, 100);

        // Reset in the middle of a frame aborts it
        fork
            send(0, 8'hFF, 0, 1'b0, 1'b1, PER);
            begin
                repeat (400) @(posedge clk);
                #1;
                rst = 1'b1;
                align();
                chk_zero_a("midframe rst");
                rst = 1'b0;
            end
        join
        drive(0, 1'b1, 100);
        qa.push_back(model(8'h81, 0, 1'b0, 1'b1));
        send(0, 8'h81, 0, 1'b0, 1'b1, PER);
        qa.push_back(model(8'h81, 0, 1'b0, 1'b1));
        send(0, 8'h81, 0, 1'b0, 1'b1, PER - 5);
        qa.push_back(model(8'h81, 0, 1'b0, 1'b1));
        send(0, 8'h81, 0, 1'b0, 1'b1, PER + 5);

        // Random traffic on both receivers in parallel
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [7:0] da;
                    da = 8'($urandom);
                    qa.push_back(model(da, 0, 1'b0, 1'b1));
                    send(0, da, 0, 1'b0, 1'b1, PER);
                    drive(0, 1'b1, $urandom_range(40, 200));
                end
            end
            begin
                for (int j = 0; j < 6; j++) begin
                    d  = 8'($urandom);
                    pb = 1'($urandom);
                    sv = ($urandom_range(0, 3) != 0);
                    qb.push_back(model(d, 1, pb, sv));
                    send(1, d, 1, pb, sv, PER);
                    drive(1, 1'b1, $urandom_range(40, 200));
                end
            end
        join

        repeat (400) @(posedge clk);
        #1;
        chk("queue a drained", 32'(qa.size()), 32'd0);
        chk("queue b drained", 32'(qb.size()), 32'd0);
        chk("final overrun a", 32'(ovr_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
